nec_ir_decoder: RTL and testbench
=================================

// Module: nec_ir_decoder
// PURPOSE
//  Upstream stage of the motor-control path. Samples the raw IR receiver output and times NEC pulse widths.
//  Assembles the 32-bit NEC frame and presents it to the motor controller's DataIn for exactly one CLK.
//  DataOut is 32'h0 at all other times, so the consumer's per-clock case decode acts once per key press.
//  Byte order matches the consumer: command byte in DataOut[23:16].
// PARAMETERS
//  CLK_FREQ   50_000_000  CLK frequency in Hz; tick divider = CLK_FREQ/100_000 (10 us tick)
//  CHECK_INV  1           1: reject frames whose complement bytes mismatch; 0: accept without check
//  REPEAT_EN  0           1: a repeat code re-presents the last good frame on DataOut; 0: Repeat pulse only
// PORTS
//  CLK        in   1   system clock
//  RST        in   1   asynchronous, active-high reset
//  IR         in   1   raw IR receiver output, active-low (mark = 0, idle = 1), asynchronous
//  DataOut    out  32  decoded frame, valid only while DataValid=1, else 32'h0
//  DataValid  out  1   1-CLK pulse: good frame on DataOut
//  Repeat     out  1   1-CLK pulse: NEC repeat code received
//  Error      out  1   1-CLK pulse: malformed/timed-out/inverse-check-failed frame
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0; last-frame register 0; synchroniser flops 1 (idle).
//  Input: 2-FF synchroniser on IR. Rise/fall detected on the synchronised level, 1 CLK after it.
//  Timebase: prescaler emits 1-CLK tick every CLK_FREQ/100_000 cycles and restarts on every IR edge.
//   - 11-bit tick counter cleared on every edge; saturates at 2047 ticks.
//  Windows, in ticks (inclusive):
//   - lead mark 800..1000
//   - lead space 400..500 (frame), 200..250 (repeat)
//   - bit mark 40..70
//   - bit space 40..70 = 0, 140..190 = 1
//   - stop mark 40..70
//  FSM:
//   - IDLE: falling edge -> LEAD_MARK.
//   - LEAD_MARK: rising edge with count in window -> LEAD_SPACE; out of window -> Error, IDLE.
//   - LEAD_SPACE: falling edge with frame space -> BIT_MARK, bit index 0. Repeat space -> STOP_MARK with rep flag set.
//     Other count -> Error, IDLE.
//   - BIT_MARK: rising edge in window -> BIT_SPACE; else Error, IDLE.
//   - BIT_SPACE: falling edge; classify 0/1, shift in LSB-first.
//     Bit index 31 done -> STOP_MARK, else BIT_MARK. Unclassifiable -> Error, IDLE.
//   - STOP_MARK: rising edge in window -> emit result, IDLE; else Error, IDLE.
//  Timeout: in any non-IDLE state, count exceeding 1000 ticks without an edge -> Error pulse, IDLE.
//   - Also exits a stuck-low line; IDLE then waits for the next falling edge.
//  Frame assembly: received bits b0..b31 in arrival order; byte k = b[8k+7:8k] (b[8k] is the byte LSB).
//   - A = byte0 address, A' = byte1, C = byte2 command, C' = byte3.
//   - DataOut = {A, C, A', C'}.
//  Emit on frame: if CHECK_INV=1 and (A'!=~A or C'!=~C) -> Error only.
//   - Otherwise DataValid=1 and DataOut=frame for one CLK, and the frame is stored as last-frame.
//  Emit on repeat: Repeat=1 for one CLK.
//   - If REPEAT_EN=1 and a last-frame is stored, DataValid=1 and DataOut=last-frame in the same cycle.
//  Latency: DataValid/Repeat/Error assert 4 CLK after the raw IR edge that completes the stop mark.
//   - 2 sync + 1 edge detect + 1 output register.
//  Exclusivity: DataValid, Error and Repeat never coincide, except DataValid+Repeat when REPEAT_EN=1.
//  RST mid-frame: everything returns to reset values immediately; partial frame discarded; no pulse emitted.
//   - Decoding resumes at the next falling edge.
// TESTING (bench may use CLK_FREQ=1_000_000, tick = 10 CLK)
//  1. Frame A=8'h00, C=8'h45 with nominal NEC timing
//     -> one DataValid pulse, DataOut=32'h0045FFBA that cycle, 32'h0 before/after; Error=0.
//  2. Repeat code (9 ms mark, 2.25 ms space, stop) after test 1, REPEAT_EN=0
//     -> Repeat pulse only, DataOut stays 0.
//     Same with REPEAT_EN=1 -> Repeat + DataValid with 32'h0045FFBA.
//  3. Frame A=8'h00, C=8'h09 with C' corrupted to 8'hF7, CHECK_INV=1
//     -> Error pulse, no DataValid.
//     Same with CHECK_INV=0 -> DataValid, DataOut=32'h0009FFF7.
//  4. Leader mark of 6 ms -> Error at its rising edge, no DataValid.
//     Then a valid frame C=8'h15 -> DataValid with DataOut=32'h0015FFEA.
//  5. IR held low 20 ms mid-frame after bit 12 -> one Error pulse 1000 ticks after the last edge, FSM IDLE.
//     Next valid frame decodes normally.
//  6. RST asserted during bit 20 of a C=8'h44 frame, released, same frame resent
//     -> no output during/after the aborted frame; DataValid with DataOut=32'h0044FFBB on resend.

Source files
------------

// File: rtl/nec_ir_decoder_if.sv
// nec_ir_decoder_if: raw IR input and decoded-frame outputs of the NEC decoder
interface nec_ir_decoder_if;
  logic IR;
  logic [31:0] DataOut;
  logic DataValid;
  logic Repeat;
  logic Error;
  modport master(input IR, output DataOut, DataValid, Repeat, Error);
  modport slave(output IR, input DataOut, DataValid, Repeat, Error);
endinterface

// File: rtl/nec_ir_decoder.sv
// nec_ir_decoder: times NEC pulse widths on a raw IR line and emits 1-CLK frame/repeat/error pulses
module nec_ir_decoder #(
  parameter int CLK_FREQ = 50_000_000,
  parameter bit CHECK_INV = 1,
  parameter bit REPEAT_EN = 0
) (
  input logic CLK,
  input logic RST,
  nec_ir_decoder_if.master bus
);
  localparam int DIV = CLK_FREQ / 100_000;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;
  state_t state, nxt;
  logic s1, s2, s3, fall, rise, ev, tick, to;
  logic [PW-1:0] presc;
  logic [10:0] cnt;
  logic [4:0] idx;
  logic rep, have_last, err_c, done, frame_ok;
  logic lm_ok, lsf_ok, lsr_ok, pm_ok, b1;
  logic [31:0] sr, last, frame, do_n;
  logic dv_n, rp_n, er_n;

  function automatic logic win(input logic [10:0] c, input int lo, input int hi);
    return int'(c) >= lo && int'(c) <= hi;
  endfunction

  assign ev = fall | rise;
  assign tick = presc == PW'(DIV - 1);
  assign to = state != IDLE && cnt > 11'd1000;
  assign lm_ok = win(cnt, 800, 1000);
  assign lsf_ok = win(cnt, 400, 500);
  assign lsr_ok = win(cnt, 200, 250);
  assign pm_ok = win(cnt, 40, 70);
  assign b1 = win(cnt, 140, 190);
  assign frame = {sr[7:0], sr[23:16], sr[15:8], sr[31:24]};
  assign frame_ok = !CHECK_INV || (sr[15:8] == ~sr[7:0] && sr[31:24] == ~sr[23:16]);

  // Edges are registered so every decision sees a stable, glitch-free event one CLK after the sync level
  always_ff @(posedge CLK or posedge RST)
    if (RST) {s1, s2, s3, fall, rise} <= 5'b11100;
    else begin
      s1 <= bus.IR;
      s2 <= s1;
      s3 <= s2;
      fall <= s3 & ~s2;
      rise <= ~s3 & s2;
    end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      presc <= '0;
      cnt <= '0;
    end else if (ev) begin
      presc <= '0;
      cnt <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt <= cnt + {10'd0, cnt != 11'd2047};
    end else presc <= presc + 1'b1;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      rep <= 1'b0;
      sr <= '0;
      last <= '0;
      have_last <= 1'b0;
    end else begin
      state <= nxt;
      if (state == LEAD_SPACE && fall) begin
        idx <= '0;
        rep <= lsr_ok;
      end
      if (state == BIT_SPACE && fall && (pm_ok | b1)) begin
        sr <= {b1, sr[31:1]};
        idx <= idx + 1'b1;
      end
      if (done && !rep && frame_ok) begin
        last <= frame;
        have_last <= 1'b1;
      end
    end

  always_comb begin
    nxt = state;
    err_c = 1'b0;
    done = 1'b0;
    if (to) begin
      nxt = IDLE;
      err_c = 1'b1;
    end else
      case (state)
        IDLE: nxt = fall ? LEAD_MARK : IDLE;
        LEAD_MARK: if (rise) begin
          nxt = lm_ok ? LEAD_SPACE : IDLE;
          err_c = !lm_ok;
        end
        LEAD_SPACE: if (fall) begin
          nxt = lsf_ok ? BIT_MARK : lsr_ok ? STOP_MARK : IDLE;
          err_c = !(lsf_ok | lsr_ok);
        end
        BIT_MARK: if (rise) begin
          nxt = pm_ok ? BIT_SPACE : IDLE;
          err_c = !pm_ok;
        end
        BIT_SPACE: if (fall) begin
          nxt = !(pm_ok | b1) ? IDLE : idx == 5'd31 ? STOP_MARK : BIT_MARK;
          err_c = !(pm_ok | b1);
        end
        STOP_MARK: if (rise) begin
          nxt = IDLE;
          done = pm_ok;
          err_c = !pm_ok;
        end
        default: nxt = IDLE;
      endcase
  end

  always_comb begin
    dv_n = done && (rep ? (REPEAT_EN && have_last) : frame_ok);
    rp_n = done && rep;
    er_n = err_c || (done && !rep && !frame_ok);
    do_n = !dv_n ? 32'h0 : rep ? last : frame;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      bus.DataValid <= 1'b0;
      bus.Repeat <= 1'b0;
      bus.Error <= 1'b0;
      bus.DataOut <= '0;
    end else begin
      bus.DataValid <= dv_n;
      bus.Repeat <= rp_n;
      bus.Error <= er_n;
      bus.DataOut <= do_n;
    end
endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb_nec_ir_decoder: one IR stream drives two decoders (strict/no-repeat and lenient/repeat) checked by scoreboards
module tb_nec_ir_decoder;
  typedef logic [34:0] ev_t;
  logic clk = 1'b0, rst = 1'b1, ir = 1'b1;
  int vecs = 0, fails = 0;
  ev_t qa[$], qb[$];

  nec_ir_decoder_if ia();
  nec_ir_decoder_if ib();
  assign ia.IR = ir;
  assign ib.IR = ir;

  nec_ir_decoder #(.CLK_FREQ(100_000), .CHECK_INV(1), .REPEAT_EN(0)) dut_a(.CLK(clk), .RST(rst), .bus(ia));
  nec_ir_decoder #(.CLK_FREQ(100_000), .CHECK_INV(0), .REPEAT_EN(1)) dut_b(.CLK(clk), .RST(rst), .bus(ib));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input ev_t act, input ev_t exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dv/rp/er/data got %b/%b/%b/%h want %b/%b/%b/%h", nm,
               act[34], act[33], act[32], act[31:0], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  always @(negedge clk) begin
    if (ia.DataValid | ia.Repeat | ia.Error) begin
      if (qa.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL a unexpected pulse dv/rp/er=%b%b%b data=%h", ia.DataValid, ia.Repeat, ia.Error, ia.DataOut);
      end else chk("a", {ia.DataValid, ia.Repeat, ia.Error, ia.DataOut}, qa.pop_front());
    end else if (ia.DataOut != 32'h0) begin
      fails++;
      $display("FAIL a idle DataOut got %h want 00000000", ia.DataOut);
    end
  end

  always @(negedge clk) begin
    if (ib.DataValid | ib.Repeat | ib.Error) begin
      if (qb.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL b unexpected pulse dv/rp/er=%b%b%b data=%h", ib.DataValid, ib.Repeat, ib.Error, ib.DataOut);
      end else chk("b", {ib.DataValid, ib.Repeat, ib.Error, ib.DataOut}, qb.pop_front());
    end else if (ib.DataOut != 32'h0) begin
      fails++;
      $display("FAIL b idle DataOut got %h want 00000000", ib.DataOut);
    end
  end

  task automatic expect_ev(input ev_t ea, input ev_t eb);
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  task automatic level(input logic v, input int n);
    ir = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bits(input logic [31:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      level(1'b0, 56);
      level(1'b1, b[i] ? 169 : 56);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ci);
    level(1'b0, 900);
    level(1'b1, 450);
    send_bits({ci, c, ~a, a}, 32);
    level(1'b0, 56);
    level(1'b1, 300);
  endtask

  task automatic send_repeat();
    level(1'b0, 900);
    level(1'b1, 225);
    level(1'b0, 56);
    level(1'b1, 300);
  endtask

  localparam ev_t DV = 35'h4_0000_0000;
  localparam ev_t RP = 35'h2_0000_0000;
  localparam ev_t ER = 35'h1_0000_0000;

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({ia.DataValid, ia.Repeat, ia.Error, ia.DataOut, ib.DataValid, ib.Repeat, ib.Error, ib.DataOut} !== 70'h0) begin
      fails++;
      $display("FAIL reset outputs got a=%b%b%b/%h b=%b%b%b/%h want all zero",
               ia.DataValid, ia.Repeat, ia.Error, ia.DataOut, ib.DataValid, ib.Repeat, ib.Error, ib.DataOut);
    end
    rst = 1'b0;
    level(1'b1, 50);
    expect_ev(DV | 35'h0045FFBA, DV | 35'h0045FFBA);
    send_frame(8'h00, 8'h45, 8'hBA);
    expect_ev(RP, DV | RP | 35'h0045FFBA);
    send_repeat();
    expect_ev(ER, DV | 35'h0009FFF7);
    send_frame(8'h00, 8'h09, 8'hF7);
    expect_ev(ER, ER);
    level(1'b0, 600);
    level(1'b1, 300);
    expect_ev(DV | 35'h0015FFEA, DV | 35'h0015FFEA);
    send_frame(8'h00, 8'h15, 8'hEA);
    expect_ev(ER, ER);
    level(1'b0, 900);
    level(1'b1, 450);
    send_bits(32'hBA45FF00, 12);
    level(1'b0, 2000);
    level(1'b1, 300);
    expect_ev(DV | 35'h0045FFBA, DV | 35'h0045FFBA);
    send_frame(8'h00, 8'h45, 8'hBA);
    level(1'b0, 900);
    level(1'b1, 450);
    send_bits(32'hBB44FF00, 20);
    level(1'b0, 30);
    rst = 1'b1;
    level(1'b1, 5);
    rst = 1'b0;
    level(1'b1, 300);
    expect_ev(RP, RP);
    send_repeat();
    expect_ev(DV | 35'h0044FFBB, DV | 35'h0044FFBB);
    send_frame(8'h00, 8'h44, 8'hBB);
    repeat (50) @(posedge clk);
    while (qa.size() != 0) begin
      ev_t e = qa.pop_front();
      vecs++;
      fails++;
      $display("FAIL a missing pulse got none want dv/rp/er=%b%b%b data=%h", e[34], e[33], e[32], e[31:0]);
    end
    while (qb.size() != 0) begin
      ev_t e = qb.pop_front();
      vecs++;
      fails++;
      $display("FAIL b missing pulse got none want dv/rp/er=%b%b%b data=%h", e[34], e[33], e[32], e[31:0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
